// File: rtl/nones_word_gen.sv
// nones_word_gen: enumerates every Width-bit word holding exactly k ones,
// in ascending order, over a valid/ready stream with sequence numbering.
module nones_word_gen #(
  parameter int Width    = 8,
  parameter int KWidth   = 5,
  parameter int SeqWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [KWidth-1:0]   k_i,
  output logic                busy_o,
  output logic [Width-1:0]    word_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                last_o,
  output logic [SeqWidth-1:0] seq_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int CW = $clog2(Width + 2) + 1;
  localparam logic [KWidth-1:0] WK = KWidth'(Width);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [KWidth-1:0]   k_q, k_d;
  logic [Width-1:0]    word_q, word_d;
  logic [SeqWidth-1:0] seq_q, seq_d;
  logic                err_q, err_d;

  logic [Width-1:0]    top;
  logic [Width-1:0]    nxt;
  logic [CW-1:0]       ctz;
  logic [CW-1:0]       sh;
  logic [Width:0]      v, c, r, x;
  logic                is_last;

  function automatic logic [Width-1:0] low_ones(logic [KWidth-1:0] k);
    return Width'(((Width+1)'(1) << k) - (Width+1)'(1));
  endfunction

  // Final word of the run: k ones packed against the MSB.
  always_comb begin
    top = low_ones(k_q) << (WK - k_q);
  end

  // Index of the lowest set bit; lower bits win.
  always_comb begin
    ctz = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (word_q[i]) ctz = CW'(i);
    end
  end

  // Next word with the same popcount, one bit wider so the carry survives.
  always_comb begin
    v   = {1'b0, word_q};
    c   = v & (-v);
    r   = v + c;
    sh  = ctz + CW'(2);
    x   = (v ^ r) >> sh;
    nxt = Width'(r | x);
  end

  assign is_last = (state_q == EMIT) && (word_q == top);

  // Next-state logic and datapath updates.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    word_d  = word_q;
    seq_d   = seq_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (k_i > WK) begin
            err_d = 1'b1;
          end else begin
            k_d     = k_i;
            word_d  = low_ones(k_i);
            seq_d   = '0;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (ready_i) begin
          if (is_last) begin
            state_d = DONE;
          end else begin
            word_d = nxt;
            seq_d  = (&seq_q) ? seq_q : seq_q + SeqWidth'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      word_q  <= '0;
      seq_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      word_q  <= word_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign valid_o = (state_q == EMIT);
  assign last_o  = is_last;
  assign done_o  = (state_q == DONE);
  assign err_o   = err_q;
  assign word_o  = word_q;
  assign seq_o   = seq_q;

endmodule

// File: doc/nones_word_gen.md
NONES_WORD_GEN -- requirements
Module: nones_word_gen

Interface
Parameters (name, default, meaning):
REQ-001 Width, 8, bit width of each generated word; legal range 2..16.
REQ-002 KWidth, 5, width of the requested ones-count; SHALL satisfy 2^KWidth > Width.
REQ-003 SeqWidth, 16, width of the emitted-word sequence counter.

Ports (name, direction, width, meaning):
REQ-004 clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-005 rst_ni, input, 1, reset, asynchronous, active-low.
REQ-006 start_i, input, 1, request to enumerate; sampled only in IDLE.
REQ-007 k_i, input, KWidth, requested number of ones; captured with start_i.
REQ-008 busy_o, output, 1, high whenever the state is not IDLE.
REQ-009 word_o, output, Width, current word; it contains exactly k ones.
REQ-010 valid_o, output, 1, word_o is valid.
REQ-011 ready_i, input, 1, consumer accepts word_o.
REQ-012 last_o, output, 1, word_o is the final word of the enumeration; qualified by valid_o.
REQ-013 seq_o, output, SeqWidth, zero-based index of word_o within the enumeration.
REQ-014 done_o, output, 1, one-cycle pulse after the last word is accepted.
REQ-015 err_o, output, 1, one-cycle pulse when start_i arrives with k_i > Width.

Function
REQ-016 The block SHALL enumerate every Width-bit word with exactly k ones, in strictly ascending unsigned order.
REQ-017 The enumeration SHALL start at (1<<k)-1 and end at the word with k ones packed into the MSBs.
REQ-018 States SHALL be IDLE, EMIT and DONE.
REQ-019 IDLE transitions:
- start_i=1 with k_i<=Width: capture k_i, go to EMIT.
- start_i=1 with k_i>Width: pulse err_o for one cycle, remain in IDLE.
REQ-020 EMIT transitions: on a handshake (valid_o & ready_i) with last_o=1, go to DONE.
REQ-021 DONE SHALL last exactly one cycle, with done_o=1, then go to IDLE.
REQ-022 Latency: start_i accepted in cycle t -> valid_o=1 with the first word in cycle t+1.
REQ-023 In EMIT, valid_o SHALL remain 1 until the last word is accepted; there are no bubbles.
REQ-024 Each handshake on a non-last word SHALL load the next word in the following cycle and increment seq_o by 1.
REQ-025 While valid_o=1 and ready_i=0, word_o, last_o and seq_o SHALL hold stable.
REQ-026 Next-word computation, using Width+1-bit intermediates so that no carry is lost:
- c = v & (-v)
- r = v + c
- next = r | (((v ^ r) >> (ctz(v)+2))), truncated to Width bits
- ctz SHALL be a priority encoder; no divider.
REQ-027 last_o SHALL be combinationally equal to (word_o == top pattern for the captured k) while in EMIT.
REQ-028 k=0 SHALL emit the single word 0 with last_o=1.
REQ-029 k=Width SHALL emit the single word of all ones with last_o=1.
REQ-030 seq_o SHALL saturate at all-ones and never wrap; word generation continues regardless.
REQ-031 start_i in EMIT or DONE SHALL be ignored: no err_o, and no change to k or the sequence.
REQ-032 valid_o, last_o, done_o and err_o SHALL be 0 outside the cases specified above.

Reset
REQ-033 rst_ni=0 SHALL asynchronously force:
- state=IDLE;
- word_o=0, seq_o=0;
- valid_o=0, last_o=0, busy_o=0, done_o=0, err_o=0.
REQ-034 Reset asserted mid-enumeration SHALL abort it with no done_o pulse.
REQ-035 After reset deasserts, the first start_i accepted SHALL begin a fresh enumeration from seq_o=0.

Verification
REQ-036 Width=4, k=2, ready_i=1 throughout -> words 0011,0101,0110,1001,1010,1100 on consecutive cycles; seq_o 0..5; last_o only with 1100; done_o the cycle after.
REQ-037 Width=4, k=0 -> one word 0000 with last_o=1; then k=4 -> one word 1111 with last_o=1; done_o after each.
REQ-038 Width=4, start_i with k_i=5 -> err_o pulse one cycle after start_i; valid_o and busy_o stay 0.
REQ-039 Width=8, k=3 with ready_i toggling pseudo-randomly ->
- exactly 56 words are accepted;
- each accepted word has popcount 3 and is strictly increasing;
- word_o is stable during every stall;
- last word is 11100000.
REQ-040 Width=8, k=4, rst_ni pulsed low after the 10th accepted word -> all outputs 0 immediately; no done_o; a new start with k=1 yields 00000001 with seq_o=0.
REQ-041 start_i asserted on every cycle during a Width=4, k=2 run -> the sequence is identical to REQ-036 and err_o stays 0.
